// File: rtl/dcache.sv
// dcache: direct-mapped, write-allocate data cache of aligned 32-bit words
// for the memory-access stage.
//
// Ports:
//   clk            system clock; all state updates on the rising edge
//   rst            asynchronous active-high reset; clears every valid bit
//   we_i           line write request from MEM (fill after LW, update after SW)
//   waddr_i[31:0]  byte address of the word being written
//   wdata_i[31:0]  word to write, little-endian
//   raddr_i[31:0]  lookup byte address (registered upstream in MEM)
//   snoop_we_i     RAM byte-write strobe seen on the memory bus
//   snoop_addr_i   RAM byte-write address
//   hit_o          combinational lookup hit for raddr_i
//   data_o[31:0]   cached word for raddr_i, zero when hit_o is low
module dcache #(
    parameter int          INDEX_W = 7,
    parameter logic [31:0] IO_BASE = 32'h30000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        we_i,
    input  logic [31:0] waddr_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] raddr_i,
    input  logic        snoop_we_i,
    input  logic [31:0] snoop_addr_i,
    output logic        hit_o,
    output logic [31:0] data_o
);

    localparam int LINES = 1 << INDEX_W;
    localparam int TAG_W = 30 - INDEX_W;

    logic [LINES-1:0] valid;
    logic [TAG_W-1:0] tag_mem  [LINES];
    logic [31:0]      data_mem [LINES];

    logic [INDEX_W-1:0] ridx, widx, sidx;
    logic [TAG_W-1:0]   rtag, wtag, stag;
    logic               wr_ok;
    logic               snoop_hit;

    assign ridx = raddr_i[INDEX_W+1:2];
    assign rtag = raddr_i[31:INDEX_W+2];
    assign widx = waddr_i[INDEX_W+1:2];
    assign wtag = waddr_i[31:INDEX_W+2];
    assign sidx = snoop_addr_i[INDEX_W+1:2];
    assign stag = snoop_addr_i[31:INDEX_W+2];

    // A write that is still under reset at the edge must not land, so the
    // array write is gated by rst as well as by alignment and cacheability.
    assign wr_ok = we_i & ~rst & (waddr_i[1:0] == 2'b00) & (waddr_i < IO_BASE);

    // The snoop ignores the byte offset: any byte store into a cached word
    // makes the whole word stale.
    assign snoop_hit = snoop_we_i & (snoop_addr_i < IO_BASE)
                     & valid[sidx] & (tag_mem[sidx] == stag);

    // Lookup is purely combinational; the array contents read here are the
    // pre-edge values, so a same-cycle write is not bypassed.
    always_comb begin
        hit_o  = 1'b0;
        data_o = 32'h0;
        if (!rst && raddr_i[1:0] == 2'b00 && raddr_i < IO_BASE
            && valid[ridx] && tag_mem[ridx] == rtag) begin
            hit_o  = 1'b1;
            data_o = data_mem[ridx];
        end
    end

    // Valid bits: the write is assigned after the snoop so that a store
    // update refilling a line it just invalidated wins at the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= '0;
        end else begin
            if (snoop_hit) begin
                valid[sidx] <= 1'b0;
            end
            if (wr_ok) begin
                valid[widx] <= 1'b1;
            end
        end
    end

    // Tag and data arrays carry no reset; the valid bits alone decide hits.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            tag_mem[widx]  <= wtag;
            data_mem[widx] <= wdata_i;
        end
    end

endmodule

// File: tb/tb_dcache.sv
// tb_dcache: directed bench for dcache. Each lookup pushes its expected
// hit/data onto a scoreboard queue when driven; checkOutput pops the entry
// and compares it against the combinational outputs.
module tb_dcache;

    logic        clk;
    logic        rst;
    logic        we_i;
    logic [31:0] waddr_i;
    logic [31:0] wdata_i;
    logic [31:0] raddr_i;
    logic        snoop_we_i;
    logic [31:0] snoop_addr_i;
    logic        hit_o;
    logic [31:0] data_o;

    int checks = 0;
    int errors = 0;

    logic        exp_hit_q  [$];
    logic [31:0] exp_data_q [$];
    string       exp_name_q [$];

    dcache #(.INDEX_W(7), .IO_BASE(32'h30000)) dut (
        .clk          (clk),
        .rst          (rst),
        .we_i         (we_i),
        .waddr_i      (waddr_i),
        .wdata_i      (wdata_i),
        .raddr_i      (raddr_i),
        .snoop_we_i   (snoop_we_i),
        .snoop_addr_i (snoop_addr_i),
        .hit_o        (hit_o),
        .data_o       (data_o)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive a lookup address and record what the cache should answer.
    task automatic applyStimulus(input logic [31:0] addr, input logic exp_hit,
                                 input logic [31:0] exp_data, input string name);
        raddr_i = addr;
        exp_hit_q.push_back(exp_hit);
        exp_data_q.push_back(exp_data);
        exp_name_q.push_back(name);
    endtask

    // Pop the oldest expectation and compare it with the DUT outputs.
    task automatic checkOutput();
        logic        eh;
        logic [31:0] ed;
        string       nm;
        #1;
        if (exp_hit_q.size() == 0) begin
            checks++;
            errors++;
            $error("[TB] FAIL scoreboard_empty actual=0 entries required>=1");
            return;
        end
        eh = exp_hit_q.pop_front();
        ed = exp_data_q.pop_front();
        nm = exp_name_q.pop_front();
        checks++;
        assert (hit_o === eh) else begin
            errors++;
            $error("[TB] FAIL %s hit_o actual=%0b required=%0b", nm, hit_o, eh);
        end
        checks++;
        assert (data_o === ed) else begin
            errors++;
            $error("[TB] FAIL %s data_o actual=%h required=%h", nm, data_o, ed);
        end
    endtask

    // Lookup without changing any other input, checked mid-cycle.
    task automatic lookup(input logic [31:0] addr, input logic exp_hit,
                          input logic [31:0] exp_data, input string name);
        @(negedge clk);
        applyStimulus(addr, exp_hit, exp_data, name);
        checkOutput();
    endtask

    // One-cycle line write.
    task automatic write_word(input logic [31:0] addr, input logic [31:0] data);
        @(negedge clk);
        we_i    = 1'b1;
        waddr_i = addr;
        wdata_i = data;
        @(negedge clk);
        we_i    = 1'b0;
    endtask

    // One-cycle snoop byte write.
    task automatic snoop(input logic [31:0] addr);
        @(negedge clk);
        snoop_we_i   = 1'b1;
        snoop_addr_i = addr;
        @(negedge clk);
        snoop_we_i   = 1'b0;
    endtask

    initial begin
        rst          = 1'b1;
        we_i         = 1'b0;
        waddr_i      = 32'h0;
        wdata_i      = 32'h0;
        raddr_i      = 32'h0;
        snoop_we_i   = 1'b0;
        snoop_addr_i = 32'h0;

        // Outputs held at zero while reset is asserted.
        #2;
        applyStimulus(32'h100, 1'b0, 32'h0, "in_reset");
        checkOutput();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        $display("[TB] basic fill and hit");
        lookup(32'h100, 1'b0, 32'h0, "cold_miss");
        write_word(32'h100, 32'hDEADBEEF);
        lookup(32'h100, 1'b1, 32'hDEADBEEF, "fill_hit");

        $display("[TB] conflict overwrite");
        write_word(32'h300, 32'h12345678);
        lookup(32'h100, 1'b0, 32'h0, "conflict_old_miss");
        lookup(32'h300, 1'b1, 32'h12345678, "conflict_new_hit");

        $display("[TB] snoop invalidation");
        write_word(32'h200, 32'h0BADF00D);
        lookup(32'h200, 1'b1, 32'h0BADF00D, "pre_snoop_hit");
        snoop(32'h202);
        lookup(32'h200, 1'b0, 32'h0, "snoop_same_word_miss");
        write_word(32'h200, 32'h55AA55AA);
        snoop(32'h204);
        lookup(32'h200, 1'b1, 32'h55AA55AA, "snoop_other_word_hit");
        snoop(32'h30200);
        lookup(32'h200, 1'b1, 32'h55AA55AA, "snoop_io_ignored");

        $display("[TB] uncacheable and unaligned");
        write_word(32'h100, 32'hCAFEF00D);
        write_word(32'h101, 32'hBAD0BAD0);
        write_word(32'h30000, 32'h13572468);
        lookup(32'h30000, 1'b0, 32'h0, "io_miss");
        lookup(32'h101, 1'b0, 32'h0, "unaligned_miss");
        lookup(32'h100, 1'b1, 32'hCAFEF00D, "unaligned_write_ignored");
        lookup(32'h0, 1'b0, 32'h0, "io_write_not_allocated");

        $display("[TB] write beats snoop, no bypass");
        write_word(32'h300, 32'h12345678);
        @(negedge clk);
        we_i         = 1'b1;
        waddr_i      = 32'h300;
        wdata_i      = 32'hA5A5A5A5;
        snoop_we_i   = 1'b1;
        snoop_addr_i = 32'h300;
        applyStimulus(32'h300, 1'b1, 32'h12345678, "same_cycle_old");
        checkOutput();
        @(negedge clk);
        we_i       = 1'b0;
        snoop_we_i = 1'b0;
        applyStimulus(32'h300, 1'b1, 32'hA5A5A5A5, "write_wins");
        checkOutput();

        $display("[TB] asynchronous reset");
        write_word(32'h400, 32'h44444444);
        write_word(32'h500, 32'h55555555);
        lookup(32'h400, 1'b1, 32'h44444444, "pre_reset_hit");
        #2;
        rst = 1'b1;
        applyStimulus(32'h400, 1'b0, 32'h0, "async_reset_drop");
        checkOutput();
        @(negedge clk);
        we_i    = 1'b1;
        waddr_i = 32'h600;
        wdata_i = 32'h66666666;
        @(posedge clk);
        #1;
        rst  = 1'b0;
        we_i = 1'b0;
        #1;
        applyStimulus(32'h600, 1'b0, 32'h0, "write_under_reset_ignored");
        checkOutput();
        lookup(32'h400, 1'b0, 32'h0, "post_reset_miss_400");
        lookup(32'h500, 1'b0, 32'h0, "post_reset_miss_500");
        lookup(32'h300, 1'b0, 32'h0, "post_reset_miss_300");

        if (exp_hit_q.size() != 0) begin
            checks++;
            errors++;
            $error("[TB] FAIL scoreboard_leftover actual=%0d entries required=0",
                   exp_hit_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
